// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU control decoder with an optional iterative multiply/divide unit.
// The MDU is compiled in only when the macro ALU_CTRL_MDU_EN is defined.
// Ports:
//   clk, reset (async, active-low)
//   part_of_inst {funct7, funct3, opcode}, alu_ctrl_op (0 = force add)
//   alu_op, is_mdu      : combinational decode of the instruction
//   in_valid / in_ready : MDU operand handshake (rs1_data, rs2_data)
//   out_valid/out_ready : MDU result handshake (result)
module alu_ctrl_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [16:0]     part_of_inst,
  input  logic            alu_ctrl_op,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [OP_W-1:0] alu_op,
  output logic            is_mdu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [6:0] OPC_ARITH   = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] F7_BASE     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRL = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_BEQ = 5'b00111;
  localparam logic [4:0] OP_BNE = 5'b01000;
  localparam logic [4:0] OP_BLT = 5'b01001;
  localparam logic [4:0] OP_BGE = 5'b01010;
  localparam logic [4:0] OP_ILL = 5'b10011;

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [6:0] opcode;
  logic [4:0] op_dec;
  logic       mdu_dec;

  assign funct7 = part_of_inst[16:10];
  assign funct3 = part_of_inst[9:7];
  assign opcode = part_of_inst[6:0];

  // Instruction decode; pure function of the inputs.
  always_comb begin
    op_dec  = OP_ILL;
    mdu_dec = 1'b0;
    if (!alu_ctrl_op) begin
      op_dec = OP_ADD;
    end else begin
      case (opcode)
        OPC_ARITH: begin
          if (funct7 == F7_BASE) begin
            case (funct3)
              3'b000:  op_dec = OP_ADD;
              3'b111:  op_dec = OP_AND;
              3'b110:  op_dec = OP_OR;
              3'b100:  op_dec = OP_XOR;
              3'b001:  op_dec = OP_SLL;
              3'b101:  op_dec = OP_SRL;
              default: op_dec = OP_ILL;
            endcase
          end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
            op_dec = OP_SUB;
`ifdef ALU_CTRL_MDU_EN
          end else if (funct7 == 7'b0000001) begin
            // MUL..REMU are consecutive codes starting at 01011
            op_dec  = 5'(5'b01011 + 5'(funct3));
            mdu_dec = 1'b1;
`endif
          end
        end
        OPC_ARITH_I: if (funct3 == 3'b000) op_dec = OP_ADD;
        OPC_LOAD:    if (funct3 == 3'b010) op_dec = OP_ADD;
        OPC_STORE:   if (funct3 == 3'b010) op_dec = OP_ADD;
        OPC_JAL:     op_dec = OP_ADD;
        OPC_JALR:    if (funct3 == 3'b000) op_dec = OP_ADD;
        OPC_BRANCH: begin
          case (funct3)
            3'b000:  op_dec = OP_BEQ;
            3'b001:  op_dec = OP_BNE;
            3'b100:  op_dec = OP_BLT;
            3'b101:  op_dec = OP_BGE;
            default: op_dec = OP_ILL;
          endcase
        end
        default: op_dec = OP_ILL;
      endcase
    end
  end

  assign alu_op = OP_W'(op_dec);
  assign is_mdu = mdu_dec;

`ifdef ALU_CTRL_MDU_EN
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, result_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, out_valid_d;

  logic             a_sgn, b_sgn, a_neg, b_neg, accept, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag, bypass_res;
  logic [XLEN:0]    mul_sum, div_sh;
  logic [XLEN-1:0]  div_diff, step_hi, step_lo, quo, rem;
  logic [PW-1:0]    prod, prod_s;
  logic [XLEN-1:0]  fin_res;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept   = in_valid && in_ready && mdu_dec;

  // Operand magnitudes and special-case detection for a new op.
  always_comb begin
    a_sgn      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn      = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg      = a_sgn && rs1_data[XLEN-1];
    b_neg      = b_sgn && rs2_data[XLEN-1];
    a_mag      = a_neg ? -rs1_data : rs1_data;
    b_mag      = b_neg ? -rs2_data : rs2_data;
    div_zero   = funct3[2] && (rs2_data == '0);
    div_ovf    = (funct3 == 3'b100 || funct3 == 3'b110) &&
                 (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    bypass_res = '1;
    if (div_zero) bypass_res = funct3[1] ? rs1_data : '1;
    else if (div_ovf) bypass_res = funct3[1] ? '0 : rs1_data;
  end

  // One shift-add or restoring-divide step, plus sign correction of the final step.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh[XLEN-1:0] - dvs_q;
    if (!op_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (div_sh >= {1'b0, dvs_q}) begin
      step_hi = div_diff;
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_sh[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -step_lo : step_lo;
    rem    = rneg_q ? -step_hi : step_hi;
    if (op_q[2])             fin_res = op_q[1] ? rem : quo;
    else if (op_q == 3'b000) fin_res = prod_s[XLEN-1:0];
    else                     fin_res = prod_s[PW-1:XLEN];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    result_d    = result;
    out_valid_d = out_valid;
    case (state_q)
      S_IDLE: ;
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          result_d    = fin_res;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new op overrides the retire path; accept is never true in CALC.
    if (accept) begin
      op_d   = funct3;
      dvs_d  = b_mag;
      hi_d   = '0;
      lo_d   = a_mag;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      if (div_zero || div_ovf) begin
        state_d     = S_DONE;
        cnt_d       = '0;
        result_d    = bypass_res;
        out_valid_d = 1'b1;
      end else begin
        state_d     = S_CALC;
        cnt_d       = CNT_W'(XLEN);
        out_valid_d = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      result    <= result_d;
      out_valid <= out_valid_d;
    end
  end
`else
  logic unused_inputs;

  assign in_ready      = 1'b1;
  assign out_valid     = 1'b0;
  assign result        = '0;
  assign unused_inputs = ^{clk, reset, in_valid, out_ready, rs1_data, rs2_data};
`endif

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard testbench for alu_ctrl_mdu (XLEN = 32). Expected MDU results are
// queued when an op is issued; a monitor pops and compares on each result
// handshake. Latency counts the accept edge as edge 1.
module tb_alu_ctrl_mdu;
  localparam logic [6:0] OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MDU     = 7'b0000001;

  logic        clk, reset;
  logic [16:0] part_of_inst;
  logic        alu_ctrl_op, in_valid, in_ready, is_mdu, out_valid, out_ready;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  alu_op;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  alu_ctrl_mdu #(.XLEN(32), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .part_of_inst(part_of_inst), .alu_ctrl_op(alu_ctrl_op),
    .in_valid(in_valid), .in_ready(in_ready), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_op(alu_op), .is_mdu(is_mdu), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake must match the oldest expected value.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        chk("mdu_result", result, exp_q.pop_front());
      end
    end
  end

  task automatic dec(input string name, input logic [6:0] f7, input logic [2:0] f3,
                     input logic [6:0] opc, input logic ctrl,
                     input logic [4:0] exp_op, input logic exp_mdu);
    part_of_inst = {f7, f3, opc};
    alu_ctrl_op  = ctrl;
    #1;
    chk({name, "_alu_op"}, 32'(alu_op), 32'(exp_op));
    chk({name, "_is_mdu"}, 32'(is_mdu), 32'(exp_mdu));
  endtask

`ifdef ALU_CTRL_MDU_EN
  localparam logic EXP_MDU = 1'b1;
  localparam logic [4:0] EXP_MUL = 5'b01011;
  localparam logic [4:0] EXP_REMU = 5'b10010;

  // Issue one MDU op, wait for accept, then measure edges until out_valid.
  task automatic mdu_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        output int waited);
    int edges;
    part_of_inst = {F7_MDU, f3, OPC_ARITH};
    alu_ctrl_op  = 1'b1;
    rs1_data     = a;
    rs2_data     = b;
    in_valid     = 1'b1;
    exp_q.push_back(exp);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({name, "_latency"}, 32'(edges), 32'(lat));
  endtask
`else
  localparam logic EXP_MDU = 1'b0;
  localparam logic [4:0] EXP_MUL = 5'b10011;
  localparam logic [4:0] EXP_REMU = 5'b10011;
`endif

  initial begin
    int w;
    reset        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    alu_ctrl_op  = 1'b1;
    part_of_inst = '0;
    rs1_data     = '0;
    rs2_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    dec("sub",       7'b0100000, 3'b000, OPC_ARITH,  1'b1, 5'b00110, 1'b0);
    dec("sub_force", 7'b0100000, 3'b000, OPC_ARITH,  1'b0, 5'b00000, 1'b0);
    dec("mul",       F7_MDU,     3'b000, OPC_ARITH,  1'b1, EXP_MUL,  EXP_MDU);
    dec("remu",      F7_MDU,     3'b111, OPC_ARITH,  1'b1, EXP_REMU, EXP_MDU);
    dec("mul_force", F7_MDU,     3'b000, OPC_ARITH,  1'b0, 5'b00000, 1'b0);
    dec("and",       7'b0000000, 3'b111, OPC_ARITH,  1'b1, 5'b00001, 1'b0);
    dec("xor",       7'b0000000, 3'b100, OPC_ARITH,  1'b1, 5'b00011, 1'b0);
    dec("srl",       7'b0000000, 3'b101, OPC_ARITH,  1'b1, 5'b00101, 1'b0);
    dec("lw",        7'b0000000, 3'b010, OPC_LOAD,   1'b1, 5'b00000, 1'b0);
    dec("bne",       7'b0000000, 3'b001, OPC_BRANCH, 1'b1, 5'b01000, 1'b0);
    dec("bge",       7'b0000000, 3'b101, OPC_BRANCH, 1'b1, 5'b01010, 1'b0);
    dec("br_ill",    7'b0000000, 3'b010, OPC_BRANCH, 1'b1, 5'b10011, 1'b0);
    @(posedge clk);
    #1;

`ifdef ALU_CTRL_MDU_EN
    mdu_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, w);
    mdu_op("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, w);
    mdu_op("mulh",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, w);
    mdu_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, w);
    mdu_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, w);
    mdu_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, w);
    mdu_op("divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, w);
    mdu_op("remu_z",    3'b111, 32'd5,        32'd0,        32'd5,        1, w);
    mdu_op("rem_z",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, w);
    mdu_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, w);
    mdu_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, w);
    mdu_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,       33, w);
    mdu_op("remu",      3'b111, 32'd100,      32'd7,        32'd2,        33, w);
    mdu_op("div_nd",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, w);
    mdu_op("rem_nd",    3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, w);

    // Backpressure: result held for 5 cycles, then retire + accept on one edge.
    out_ready = 1'b0;
    mdu_op("mul_bp", 3'b000, 32'd6, 32'd7, 32'd42, 33, w);
    repeat (5) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd42);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    mdu_op("mul_b2b", 3'b000, 32'd3, 32'd5, 32'd15, 33, w);
    chk("b2b_wait", 32'(w), 32'd0);

    // Reset during iteration 10 of a DIV discards it.
    part_of_inst = {F7_MDU, 3'b100, OPC_ARITH};
    rs1_data     = 32'd100;
    rs2_data     = 32'd7;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    mdu_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, w);
`else
    begin
      logic saw_valid;
      saw_valid    = 1'b0;
      part_of_inst = {F7_MDU, 3'b000, OPC_ARITH};
      rs1_data     = 32'd3;
      rs2_data     = 32'd4;
      in_valid     = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) saw_valid = 1'b1;
      end
      in_valid = 1'b0;
      chk("nomdu_out_valid", 32'(saw_valid), 32'd0);
      chk("nomdu_in_ready", 32'(in_ready), 32'd1);
      chk("nomdu_result", result, 32'd0);
    end
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter OP_W, default 5, alu_op width.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- part_of_inst  in  17  {funct7[16:10], funct3[9:7], opcode[6:0]}.
- alu_ctrl_op  in  1  0 = force add, 1 = decode.
- in_valid  in  1  operands/instruction valid.
- in_ready  out  1  MDU can accept.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B.
- alu_op  out  OP_W  decoded op, combinational.
- is_mdu  out  1  decoded op is multiply/divide, combinational.
- out_valid  out  1  MDU result valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  MDU result.

Function
REQ-004 SHALL drive alu_op = 00000 and is_mdu = 0 when alu_ctrl_op = 0, regardless of part_of_inst.
REQ-005 SHALL decode base ops using the shared opcode/funct constants: ADD/ADDI/LW/SW/JAL/JALR 00000, AND 00001, OR 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, BEQ 00111, BNE 01000, BLT 01001, BGE 01010; any unlisted encoding 10011.
REQ-006 SHALL decode opcode ARITHMETIC with funct7 0000001 by funct3 000..111 as MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010, with is_mdu = 1.
REQ-007 SHALL accept an MDU op on a rising edge where in_valid & in_ready & is_mdu; non-MDU ops never change MDU state.
REQ-008 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state == IDLE) | (state == DONE & out_ready).
REQ-009 SHALL on accept latch operands and op, load iteration counter with XLEN, enter CALC.
REQ-010 SHALL in CALC perform one shift-add (multiply) or one restoring-divide step per cycle on magnitudes, decrement counter, enter DONE after exactly XLEN iterations; out_valid rises XLEN+1 edges after accept.
REQ-011 SHALL bypass CALC (accept -> DONE, out_valid one edge after accept) for divide by zero and signed overflow.
REQ-012 SHALL produce: divide by zero quotient = all ones, remainder = rs1; DIV/REM of -2^(XLEN-1) by -1 quotient = rs1, remainder = 0.
REQ-013 SHALL apply sign correction per op: MUL low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of signed*signed / signed*unsigned / unsigned*unsigned 2*XLEN-bit product; quotient truncates toward zero, remainder takes dividend sign.
REQ-014 SHALL hold result and out_valid stable in DONE until out_ready = 1; leave DONE on that edge.
REQ-015 SHALL, when DONE & out_ready & in_valid & is_mdu coincide, retire the current result and accept the new op on the same edge (back-to-back).
REQ-016 SHALL ignore in_valid while in CALC.

Reset
REQ-017 SHALL on reset = 0 immediately force state IDLE, out_valid 0, result 0, counter 0, latched operands 0, discarding any in-flight op.
REQ-018 SHALL drive in_ready = 1 during and after reset; alu_op and is_mdu remain pure functions of inputs.

Configuration
REQ-019 SHALL use macro ALU_CTRL_MDU_EN: defined -> REQ-006..REQ-016 active; undefined -> funct7 0000001 decodes to 10011, is_mdu = 0, no FSM or datapath is synthesised, in_ready = 1, out_valid = 0, result = 0.

Verification (XLEN = 32, ALU_CTRL_MDU_EN defined)
REQ-020 SHALL cover decode: funct7 0100000, funct3 000, opcode ARITHMETIC -> alu_op 00110; same with alu_ctrl_op = 0 -> 00000; MUL encoding -> 01011, is_mdu 1.
REQ-021 SHALL cover MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 33 edges after accept; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-022 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 one edge after accept; REM same operands -> 0; DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-023 SHALL cover backpressure: out_ready low 5 cycles in DONE -> result and out_valid constant, in_ready 0; out_ready high with next MDU op valid -> back-to-back accept, no idle cycle.
REQ-024 SHALL cover reset asserted at iteration 10 of a DIV -> out_valid 0, result 0 immediately; after release in_ready 1, next MUL 3 * 4 -> 12.
REQ-025 SHALL rerun REQ-020 with ALU_CTRL_MDU_EN undefined -> MUL encoding gives 10011, out_valid never rises.
